pec_row_ctrl: RTL and testbench

PEC_ROW_CTRL -- requirements
Module: pec_row_ctrl

---
 rtl/pec_row_ctrl.sv | 118 +++++++++++
 tb/tb_pec_row_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pec_row_ctrl.sv
// Row sequencer for a PE cluster: walks one output row column by column, starting
// the three MAC lanes, waiting for all of them, then pulsing psum accumulation.
module pec_row_ctrl #(
    parameter  int LENPSUM     = 14,
    parameter  int BLOCK_DEPTH = 32,
    parameter  int KERNEL_SIZE = 9,
    localparam int AW          = $clog2(BLOCK_DEPTH * KERNEL_SIZE),
    localparam int CW          = $clog2(LENPSUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CTRL_Start,
    input  logic          CTRL_Abort,
    input  logic [1:0]    CFG_WeiRow,
    input  logic          CTRL_DatRdy,
    input  logic          MACPEC_Fnh0,
    input  logic          MACPEC_Fnh1,
    input  logic          MACPEC_Fnh2,
    output logic          PECMAC_Sta,
    output logic          PECCNV_PlsAcc,
    output logic          PECCNV_FnhRow,
    output logic [AW-1:0] PECMAC_AddrBaseWei0,
    output logic [AW-1:0] PECMAC_AddrBaseWei1,
    output logic [AW-1:0] PECMAC_AddrBaseWei2,
    output logic [CW-1:0] CTRL_Col,
    output logic          CTRL_Busy,
    output logic          CTRL_Done
);

    typedef enum logic [2:0] {IDLE, STA, WAIT, ACC, ROWEND} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(LENPSUM - 1);

    state_t     state, next_state;
    logic [CW-1:0] col;
    logic [2:0] flags;
    logic [1:0] wei_row;
    logic [2:0] fnh_now;
    logic       sta, pls_acc, row_end;

    assign fnh_now = {MACPEC_Fnh2, MACPEC_Fnh1, MACPEC_Fnh0};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        sta        = 1'b0;
        pls_acc    = 1'b0;
        row_end    = 1'b0;
        case (state)
            IDLE:   if (CTRL_Start) next_state = STA;
            STA:    if (CTRL_DatRdy) begin
                        sta        = 1'b1;
                        next_state = WAIT;
                    end
            WAIT:   if (&(flags | fnh_now)) next_state = ACC;
            ACC:    begin
                        pls_acc    = 1'b1;
                        next_state = (col == COL_LAST) ? ROWEND : STA;
                    end
            ROWEND: begin
                        row_end    = 1'b1;
                        next_state = IDLE;
                    end
            default: next_state = IDLE;
        endcase
        // Abort beats everything, including a same-cycle Start and the current pulse.
        if (CTRL_Abort) begin
            next_state = IDLE;
            sta        = 1'b0;
            pls_acc    = 1'b0;
            row_end    = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            col     <= '0;
            flags   <= '0;
            wei_row <= '0;
        end else begin
            state <= next_state;
            if (CTRL_Abort) begin
                col   <= '0;
                flags <= '0;
            end else begin
                case (state)
                    IDLE:   if (CTRL_Start) begin
                                wei_row <= (CFG_WeiRow == 2'd3) ? 2'd2 : CFG_WeiRow;
                                col     <= '0;
                            end
                    STA:    if (CTRL_DatRdy) flags <= '0;
                    WAIT:   flags <= flags | fnh_now;
                    ACC:    if (col != COL_LAST) col <= col + CW'(1);
                    ROWEND: col <= '0;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [AW-1:0] base_addr(input logic [1:0] row, input int lane);
        return AW'((3 * int'(row) + lane) * BLOCK_DEPTH);
    endfunction

    assign PECMAC_AddrBaseWei0 = base_addr(wei_row, 0);
    assign PECMAC_AddrBaseWei1 = base_addr(wei_row, 1);
    assign PECMAC_AddrBaseWei2 = base_addr(wei_row, 2);

    assign PECMAC_Sta    = sta;
    assign PECCNV_PlsAcc = pls_acc;
    assign PECCNV_FnhRow = row_end;
    assign CTRL_Done     = row_end;
    assign CTRL_Col      = col;
    assign CTRL_Busy     = (state != IDLE);

endmodule

// File: tb/tb_pec_row_ctrl.sv
// Self-checking bench for pec_row_ctrl: table of row scenarios driven open-loop,
// with a scoreboard of expected pulses (kind, cycle, column) checked by a monitor.
module tb_pec_row_ctrl;

    localparam int LENPSUM = 14;

    logic       clk = 1'b0;
    logic       rst;
    logic       CTRL_Start, CTRL_Abort, CTRL_DatRdy;
    logic [1:0] CFG_WeiRow;
    logic [2:0] fnh;
    logic       PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, CTRL_Busy, CTRL_Done;
    logic [8:0] base0, base1, base2;
    logic [3:0] CTRL_Col;

    pec_row_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .CTRL_Start          (CTRL_Start),
        .CTRL_Abort          (CTRL_Abort),
        .CFG_WeiRow          (CFG_WeiRow),
        .CTRL_DatRdy         (CTRL_DatRdy),
        .MACPEC_Fnh0         (fnh[0]),
        .MACPEC_Fnh1         (fnh[1]),
        .MACPEC_Fnh2         (fnh[2]),
        .PECMAC_Sta          (PECMAC_Sta),
        .PECCNV_PlsAcc       (PECCNV_PlsAcc),
        .PECCNV_FnhRow       (PECCNV_FnhRow),
        .PECMAC_AddrBaseWei0 (base0),
        .PECMAC_AddrBaseWei1 (base1),
        .PECMAC_AddrBaseWei2 (base2),
        .CTRL_Col            (CTRL_Col),
        .CTRL_Busy           (CTRL_Busy),
        .CTRL_Done           (CTRL_Done)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_STA = 1, EV_ACC = 2, EV_ROW = 3} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       at;
        int       col;
    } ev_t;

    // One row scenario; -1 disables an option. Bases are the expected addresses.
    typedef struct {
        logic [1:0] wr;
        int gap, stall_col, stall_n, split_col, busy_start_col;
        int abort_col, abort_mode, rst_col;
        int b0, b1, b2;
    } vec_t;

    ev_t  sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    vec_t vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input ev_kind_e k, input int at, input int col);
        sb.push_back('{kind: k, at: at, col: col});
    endtask

    task automatic match(input ev_kind_e k);
        ev_t e;
        if (sb.size() == 0) begin
            check("spurious_pulse", 32'(k), 32'd0);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", 32'(k), 32'(e.kind));
            check("pulse_cycle", 32'(cyc), 32'(e.at));
            if (k == EV_ACC) check("acc_col", 32'(CTRL_Col), 32'(e.col));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                check("missed_pulse_kind", 32'd0, 32'(sb[0].kind));
                void'(sb.pop_front());
            end
            if (PECMAC_Sta)    match(EV_STA);
            if (PECCNV_PlsAcc) match(EV_ACC);
            if (PECCNV_FnhRow) match(EV_ROW);
            if (PECCNV_FnhRow || CTRL_Done) check("done_eq_fnhrow", 32'(CTRL_Done), 32'(PECCNV_FnhRow));
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(CTRL_Busy), 32'd0);
        check({tag, "_col"},  32'(CTRL_Col),  32'd0);
    endtask

    task automatic check_bases(input string tag, input vec_t v);
        check({tag, "_base0"}, 32'(base0), 32'(v.b0));
        check({tag, "_base1"}, 32'(base1), 32'(v.b1));
        check({tag, "_base2"}, 32'(base2), 32'(v.b2));
    endtask

    task automatic run_row(input vec_t v);
        CFG_WeiRow  = v.wr;
        CTRL_Start  = 1'b1;
        CTRL_DatRdy = 1'b1;
        step();
        CTRL_Start = 1'b0;
        CFG_WeiRow = 2'(v.wr + 2'd1);
        for (int col = 0; col < LENPSUM; col++) begin
            if (col == v.stall_col) begin
                CTRL_DatRdy = 1'b0;
                for (int i = 0; i < v.stall_n; i++) begin
                    check("stall_col_held", 32'(CTRL_Col), 32'(col));
                    step();
                end
                CTRL_DatRdy = 1'b1;
            end
            expect_ev(EV_STA, cyc, col);
            step();
            if (col == 0) begin
                check("row_busy", 32'(CTRL_Busy), 32'd1);
                check_bases("row_start", v);
            end
            if (col == v.abort_col && v.abort_mode == 1) begin
                step();
                CTRL_Abort = 1'b1;
                step();
                CTRL_Abort = 1'b0;
                check_idle("abort_wait");
                return;
            end
            if (col == v.rst_col) begin
                step();
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_idle("mid_rst");
                check("mid_rst_base0", 32'(base0), 32'd0);
                check("mid_rst_base1", 32'(base1), 32'd32);
                check("mid_rst_base2", 32'(base2), 32'd64);
                return;
            end
            if (col == v.busy_start_col) begin
                CTRL_Start = 1'b1;
                CFG_WeiRow = 2'd0;
            end
            if (col == v.split_col) begin
                fnh = 3'b001; step();
                fnh = 3'b000; step();
                fnh = 3'b100; step();
                fnh = 3'b000; step();
                step();
                fnh = 3'b010;
                expect_ev(EV_ACC, cyc + 1, col);
                step();
            end else begin
                repeat (v.gap - 1) step();
                fnh = 3'b111;
                if (!(col == v.abort_col && v.abort_mode == 2)) expect_ev(EV_ACC, cyc + 1, col);
                step();
            end
            fnh        = 3'b000;
            CTRL_Start = 1'b0;
            if (col == v.abort_col && v.abort_mode == 2) begin
                CTRL_Abort = 1'b1;
                step();
                CTRL_Abort = 1'b0;
                check_idle("abort_acc");
                return;
            end
            step();
        end
        expect_ev(EV_ROW, cyc, 0);
        check_bases("row_end", v);
        step();
        check_idle("after_row");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          wr   gap stl sn spl bsy abc abm rst  b0   b1   b2
        vecs[0] = '{2'd1, 3, -1, 0, -1, -1, -1, 0, -1,  96, 128, 160};
        vecs[1] = '{2'd0, 1,  4, 4, -1, -1, -1, 0, -1,   0,  32,  64};
        vecs[2] = '{2'd2, 2, -1, 0,  6, -1, -1, 0, -1, 192, 224, 256};
        vecs[3] = '{2'd3, 1, -1, 0, -1,  3, -1, 0, -1, 192, 224, 256};
        vecs[4] = '{2'd1, 2, -1, 0, -1, -1,  5, 1, -1,  96, 128, 160};
        vecs[5] = '{2'd2, 1, -1, 0, -1, -1, -1, 0, -1, 192, 224, 256};
        vecs[6] = '{2'd0, 1, -1, 0, -1, -1,  2, 2, -1,   0,  32,  64};
        vecs[7] = '{2'd1, 1, -1, 0, -1, -1, -1, 0, -1,  96, 128, 160};
        vecs[8] = '{2'd2, 1, -1, 0, -1, -1, -1, 0,  7, 192, 224, 256};
        vecs[9] = '{2'd3, 2, 13, 2,  0, -1, -1, 0, -1, 192, 224, 256};

        rst         = 1'b1;
        CTRL_Start  = 1'b0;
        CTRL_Abort  = 1'b0;
        CTRL_DatRdy = 1'b0;
        CFG_WeiRow  = 2'd0;
        fnh         = 3'b000;
        repeat (2) step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_sta",    32'(PECMAC_Sta),    32'd0);
        check("reset_plsacc", 32'(PECCNV_PlsAcc), 32'd0);
        check("reset_fnhrow", 32'(PECCNV_FnhRow), 32'd0);
        check("reset_done",   32'(CTRL_Done),     32'd0);
        check("reset_base0",  32'(base0), 32'd0);
        check("reset_base1",  32'(base1), 32'd32);
        check("reset_base2",  32'(base2), 32'd64);
        mon_en = 1'b1;

        // Stray finish pulses while idle must not start anything.
        fnh = 3'b111;
        repeat (3) step();
        fnh = 3'b000;
        check("stray_fnh_busy", 32'(CTRL_Busy), 32'd0);

        // Abort wins over a same-cycle Start; WeiRow is not latched either.
        CTRL_Start  = 1'b1;
        CTRL_Abort  = 1'b1;
        CTRL_DatRdy = 1'b1;
        CFG_WeiRow  = 2'd3;
        step();
        CTRL_Start = 1'b0;
        CTRL_Abort = 1'b0;
        check("start_abort_busy", 32'(CTRL_Busy), 32'd0);
        check("start_abort_base0", 32'(base0), 32'd0);
        step();

        for (int i = 0; i < 10; i++) begin
            run_row(vecs[i]);
            repeat (2) step();
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
